// File: rtl/cpe_weight_preloader.sv
// Weight preloader for one CPE column of the systolic array.
// It fetches ROWS 4-bit weights from a synchronous RAM with 1-cycle read
// latency. The weights go out last-row first so that, after ROWS shifts,
// CPE row r holds the weight stored at base+r.
module cpe_weight_preloader #(
  parameter int ROWS       = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_rd_data,
  output logic [3:0]            Compensation_Weight,
  output logic                  Compensation_Weight_out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_rd_vld;
  logic [3:0]            r_weight;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_last_rd;
  logic [ADDR_WIDTH-1:0] w_start_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // The first read is the highest row. Each later read is the next lower row,
  // and the address wraps modulo 2^ADDR_WIDTH.
  assign w_last_rd    = (r_rd_cnt == CW'(ROWS - 1));
  assign w_start_addr = base_addr + ADDR_WIDTH'(ROWS - 1);
  assign w_next_addr  = r_base + ADDR_WIDTH'(ROWS - 2) - ADDR_WIDTH'(r_rd_cnt);

  // Control FSM. It issues ROWS reads, waits for the last weight to go out, then pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_rd_cnt    <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base      <= base_addr;
            r_rd_cnt    <= '0;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= w_start_addr;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_last_rd) begin
            r_mem_rd_en <= 1'b0;
            r_state     <= S_DRAIN;
          end else begin
            r_rd_cnt   <= r_rd_cnt + CW'(1);
            r_mem_addr <= w_next_addr;
          end
        end
        S_DRAIN: begin
          // The last weight is on the output when valid is high and no read is still in flight.
          if (r_valid && !r_rd_vld) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_rd_en <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Read-return pipeline. RAM data arrives one cycle after the read enable and is forwarded unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_weight <= 4'd0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_vld <= r_mem_rd_en;
      if (r_rd_vld) begin
        r_weight <= mem_rd_data;
        r_valid  <= 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign mem_rd_en                     = r_mem_rd_en;
  assign mem_addr                      = r_mem_addr;
  assign Compensation_Weight           = r_weight;
  assign Compensation_Weight_out_valid = r_valid;
  assign busy                          = r_busy;
  assign done                          = r_done;

endmodule
